branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencing controller for conditional branches in the RV32I core. It accepts one decoded branch per handshake and evaluates the condition against the register operands. It computes the target as PC + sign-extended immediate, issues a PC redirect to fetch over a valid/ready handshake, and then holds a pipeline flush for a fixed number of cycles. It sits between the branch decode stage and the fetch/PC logic and owns the only path that redirects the PC for branches.

## Interface
- XLEN, 32, operand and PC width
- FLUSH_CYCLES, 2, cycles `flush` is held after an accepted redirect (≥1)
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- br_valid  in  1  decoded branch offered
- br_ready  out  1  controller can accept a branch
- br_pc  in  XLEN  PC of the branch instruction
- br_imm  in  13  branch offset; bit 0 is always 0; signed
- br_control  in  3  condition code, using the `BEQ/`BNE/`BLT/`BGE/`BLTU/`BGEU encodings
- rs1_val, rs2_val  in  XLEN  operand values
- redirect_valid  out  1  redirect offered to fetch
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  XLEN  target PC
- flush  out  1  squash younger instructions
- illegal  out  1  one-cycle pulse: undefined br_control code
- misaligned  out  1  one-cycle pulse: taken target not 4-byte aligned
- taken_count  out  16  number of redirects accepted; saturating

## Operation
- Reset values: state IDLE, br_ready=1, redirect_valid=0, redirect_pc=0, flush=0, illegal=0, misaligned=0, taken_count=0.
- **IDLE**
  - br_ready=1.
  - On br_valid&&br_ready, register pc, imm, control and both operands, then go to EVAL.
- **EVAL** (one cycle; br_ready=0)
  - Compute `taken`:
    - BEQ/BNE: equality.
    - BLT/BGE: signed compare.
    - BLTU/BGEU: unsigned compare.
  - Compute target = pc + sext(imm), modulo 2^XLEN (wrap-around is legal and produces no error).
  - Undefined code: not taken, pulse `illegal`, go to IDLE.
  - Not taken: go to IDLE.
  - Taken with target[1:0]≠0: pulse `misaligned`, no redirect, go to IDLE.
  - Taken and aligned: load redirect_pc, go to REDIRECT.
- **REDIRECT**
  - redirect_valid=1, with redirect_pc stable until the handshake.
  - On redirect_ready:
    - increment taken_count, unless it is 16'hFFFF;
    - load the flush counter with FLUSH_CYCLES;
    - go to FLUSH.
- **FLUSH**
  - flush=1 and redirect_valid=0.
  - Decrement the counter each cycle; go to IDLE after FLUSH_CYCLES cycles.
- br_valid is ignored in every state except IDLE. The upstream stage holds the branch until it sees br_ready.
- rst_n low in any state returns every output to its reset value immediately. A branch in flight is discarded, and no redirect or flush is issued for it.

## Timing
- Accept edge is cycle 0.
- EVAL result is registered at cycle 1.
- redirect_valid is high from cycle 2 at the earliest.
- Not-taken / illegal / misaligned branch: br_ready returns high in cycle 2, giving a throughput of one branch per 2 cycles.
- Taken branch with redirect_ready already high:
  - redirect accepted in cycle 2;
  - flush high in cycles 3 .. 2+FLUSH_CYCLES;
  - br_ready high in cycle 3+FLUSH_CYCLES.
- illegal and misaligned are asserted during the cycle after EVAL, for exactly one cycle.
- redirect_ready asserted outside REDIRECT has no effect.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- The condition encodings stay in the existing processor defines include.
- New package branch_ctrl_pkg holds:
  - the FSM state enum (IDLE, EVAL, REDIRECT, FLUSH);
  - the default FLUSH_CYCLES;
  - the taken_count saturation constant.
- Sub-module branch_cond_eval (combinational): control and operands in, `taken` and `illegal` out. Reused by later forwarding/predict work.
- Waveform dump is gated by SUBMODULE_DISABLE_WAVES, like the other submodules.

## Test plan
- **BEQ taken.** pc=0x100, imm=+16, rs1=rs2=5, redirect_ready=1 → redirect_pc=0x110 in cycle 2; flush high for 2 cycles; taken_count=1.
- **BLT vs BLTU.** rs1=0xFFFFFFFF, rs2=1: BLT is taken, BLTU is not taken (no redirect_valid, br_ready back in cycle 2).
- **Backward branch with wrap.** pc=0x4, imm=-8 (13'h1FF8) → redirect_pc=0xFFFFFFFC; no error flags.
- **Stalled fetch.** Hold redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc stay stable, br_valid is ignored, then one redirect and one count increment.
- **Error codes.** br_control=3'b010 → illegal pulses once, no redirect. BNE taken with imm=+6 → misaligned pulses, no redirect.
- **Reset and saturation.**
  - rst_n low in REDIRECT → redirect_valid=0 immediately; after release, br_ready=1 and taken_count=0.
  - Preload taken_count to 0xFFFF and issue a redirect → taken_count stays at 0xFFFF.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the conditional-branch redirect controller.
package branch_ctrl_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned IMM_W            = 13;
  localparam int unsigned CTRL_W           = 3;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned TAKEN_CNT_W      = 16;
  localparam logic [TAKEN_CNT_W-1:0] TAKEN_CNT_MAX = 16'hFFFF;

  // RV32I funct3 condition codes.
  localparam logic [CTRL_W-1:0] BR_BEQ  = 3'b000;
  localparam logic [CTRL_W-1:0] BR_BNE  = 3'b001;
  localparam logic [CTRL_W-1:0] BR_BLT  = 3'b100;
  localparam logic [CTRL_W-1:0] BR_BGE  = 3'b101;
  localparam logic [CTRL_W-1:0] BR_BLTU = 3'b110;
  localparam logic [CTRL_W-1:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: decides taken and flags undefined codes.
module branch_cond_eval
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [CTRL_W-1:0] control,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic              taken_c,
  output logic              illegal_c
);

  logic eq_c;
  logic lt_s_c;
  logic lt_u_c;

  assign eq_c   = (rs1_val == rs2_val);
  assign lt_s_c = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u_c = (rs1_val < rs2_val);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (control)
      BR_BEQ:  taken_c = eq_c;
      BR_BNE:  taken_c = !eq_c;
      BR_BLT:  taken_c = lt_s_c;
      BR_BGE:  taken_c = !lt_s_c;
      BR_BLTU: taken_c = lt_u_c;
      BR_BGEU: taken_c = !lt_u_c;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Accepts one decoded branch, evaluates it, redirects fetch when taken and
// holds a fixed-length flush afterwards.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br_valid,
  output logic                   br_ready,
  input  logic [XLEN-1:0]        br_pc,
  input  logic [IMM_W-1:0]       br_imm,
  input  logic [CTRL_W-1:0]      br_control,
  input  logic [XLEN-1:0]        rs1_val,
  input  logic [XLEN-1:0]        rs2_val,
  output logic                   redirect_valid,
  input  logic                   redirect_ready,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   flush,
  output logic                   illegal,
  output logic                   misaligned,
  output logic [TAKEN_CNT_W-1:0] taken_count
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  br_state_t              state_q, state_d;
  logic [XLEN-1:0]        pc_q, rs1_q, rs2_q;
  logic [IMM_W-1:0]       imm_q;
  logic [CTRL_W-1:0]      ctrl_q;
  logic                   br_ready_q, br_ready_d;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
  logic                   flush_q, flush_d;
  logic                   illegal_q, illegal_d;
  logic                   misaligned_q, misaligned_d;
  logic [TAKEN_CNT_W-1:0] taken_count_q, taken_count_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   load_br_c;
  logic                   taken_c, illegal_c;
  logic [XLEN-1:0]        target_c;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .control   (ctrl_q),
    .rs1_val   (rs1_q),
    .rs2_val   (rs2_q),
    .taken_c   (taken_c),
    .illegal_c (illegal_c)
  );

  // Wrap-around on the add is intentional and not an error.
  assign target_c = pc_q + {{(XLEN-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  always_comb begin
    state_d          = state_q;
    br_ready_d       = br_ready_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    illegal_d        = 1'b0;
    misaligned_d     = 1'b0;
    taken_count_d    = taken_count_q;
    cnt_d            = cnt_q;
    load_br_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        br_ready_d = 1'b1;
        if (br_valid && br_ready_q) begin
          load_br_c  = 1'b1;
          br_ready_d = 1'b0;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_d    = ST_IDLE;
        br_ready_d = 1'b1;
        if (illegal_c) begin
          illegal_d = 1'b1;
        end else if (taken_c) begin
          if (target_c[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
          end else begin
            redirect_pc_d    = target_c;
            redirect_valid_d = 1'b1;
            br_ready_d       = 1'b0;
            state_d          = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          redirect_valid_d = 1'b0;
          flush_d          = 1'b1;
          cnt_d            = CNT_W'(FLUSH_CYCLES);
          state_d          = ST_FLUSH;
          if (taken_count_q != TAKEN_CNT_MAX) begin
            taken_count_d = taken_count_q + TAKEN_CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d      = '0;
          flush_d    = 1'b0;
          br_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d          = ST_IDLE;
        br_ready_d       = 1'b1;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      br_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      illegal_q        <= 1'b0;
      misaligned_q     <= 1'b0;
      taken_count_q    <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      br_ready_q       <= br_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      illegal_q        <= illegal_d;
      misaligned_q     <= misaligned_d;
      taken_count_q    <= taken_count_d;
      cnt_q            <= cnt_d;
    end
  end

  // Captured branch operands, loaded only on the accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      imm_q  <= '0;
      ctrl_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (load_br_c) begin
      pc_q   <= br_pc;
      imm_q  <= br_imm;
      ctrl_q <= br_control;
      rs1_q  <= rs1_val;
      rs2_q  <= rs2_val;
    end
  end

  assign br_ready       = br_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign illegal        = illegal_q;
  assign misaligned     = misaligned_q;
  assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; outputs sampled on the falling edge.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic        br_ready;
  logic [31:0] br_pc;
  logic [12:0] br_imm;
  logic [2:0]  br_control;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal;
  logic        misaligned;
  logic [15:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_redirect_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .br_control     (br_control),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .illegal        (illegal),
    .misaligned     (misaligned),
    .taken_count    (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offer a branch; returns at the falling edge of cycle 1 (after the accept edge).
  task automatic send(input logic [31:0] pc, input logic [12:0] imm, input logic [2:0] ctl,
                      input logic [31:0] a, input logic [31:0] b);
    br_valid   = 1'b1;
    br_pc      = pc;
    br_imm     = imm;
    br_control = ctl;
    rs1_val    = a;
    rs2_val    = b;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_pc = '0; br_imm = '0; br_control = '0;
    rs1_val = '0; rs2_val = '0; redirect_ready = 1'b1;
    step(2);
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_rvalid", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_count", 32'(taken_count), 32'd0);
    rst_n = 1'b1;
    step(1);

    // BEQ taken
    send(32'h100, 13'd16, 3'b000, 32'd5, 32'd5);
    chk("beq_c1_ready", 32'(br_ready), 32'd0);
    step(1);
    chk("beq_c2_rvalid", 32'(redirect_valid), 32'd1);
    chk("beq_c2_rpc", redirect_pc, 32'h110);
    step(1);
    chk("beq_c3_flush", 32'(flush), 32'd1);
    chk("beq_c3_rvalid", 32'(redirect_valid), 32'd0);
    chk("beq_c3_count", 32'(taken_count), 32'd1);
    step(1);
    chk("beq_c4_flush", 32'(flush), 32'd1);
    chk("beq_c4_ready", 32'(br_ready), 32'd0);
    step(1);
    chk("beq_c5_flush", 32'(flush), 32'd0);
    chk("beq_c5_ready", 32'(br_ready), 32'd1);

    // BLT taken (signed -1 < 1)
    send(32'h200, 13'h020, 3'b100, 32'hFFFF_FFFF, 32'd1);
    step(1);
    chk("blt_rvalid", 32'(redirect_valid), 32'd1);
    chk("blt_rpc", redirect_pc, 32'h220);
    step(3);
    chk("blt_count", 32'(taken_count), 32'd2);
    chk("blt_ready", 32'(br_ready), 32'd1);

    // BLTU not taken (0xFFFFFFFF > 1 unsigned)
    send(32'h200, 13'h020, 3'b110, 32'hFFFF_FFFF, 32'd1);
    step(1);
    chk("bltu_rvalid", 32'(redirect_valid), 32'd0);
    chk("bltu_ready", 32'(br_ready), 32'd1);
    chk("bltu_count", 32'(taken_count), 32'd2);

    // Backward branch wrapping below zero
    send(32'h4, 13'h1FF8, 3'b000, 32'd9, 32'd9);
    step(1);
    chk("wrap_rpc", redirect_pc, 32'hFFFF_FFFC);
    chk("wrap_illegal", 32'(illegal), 32'd0);
    chk("wrap_misal", 32'(misaligned), 32'd0);
    step(3);
    chk("wrap_count", 32'(taken_count), 32'd3);

    // Stalled fetch: redirect held, br_valid ignored
    redirect_ready = 1'b0;
    send(32'h1000, 13'h040, 3'b001, 32'd1, 32'd2);
    step(1);
    br_valid = 1'b1; br_pc = 32'h8000; br_imm = 13'h100; br_control = 3'b000;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", 32'(redirect_valid), 32'd1);
      chk("stall_rpc", redirect_pc, 32'h1040);
      chk("stall_ready", 32'(br_ready), 32'd0);
      step(1);
    end
    chk("stall_count", 32'(taken_count), 32'd3);
    redirect_ready = 1'b1;
    br_valid = 1'b0;
    step(1);
    chk("stall_flush", 32'(flush), 32'd1);
    chk("stall_rvalid_lo", 32'(redirect_valid), 32'd0);
    chk("stall_count_inc", 32'(taken_count), 32'd4);
    step(2);
    chk("stall_ready_back", 32'(br_ready), 32'd1);

    // Undefined condition code
    send(32'h300, 13'h010, 3'b010, 32'd0, 32'd0);
    step(1);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_rvalid", 32'(redirect_valid), 32'd0);
    chk("ill_ready", 32'(br_ready), 32'd1);
    step(1);
    chk("ill_pulse_end", 32'(illegal), 32'd0);

    // Taken branch to a misaligned target
    send(32'h100, 13'd6, 3'b001, 32'd1, 32'd2);
    step(1);
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_rvalid", 32'(redirect_valid), 32'd0);
    step(1);
    chk("mis_pulse_end", 32'(misaligned), 32'd0);
    chk("mis_count", 32'(taken_count), 32'd4);

    // Reset while a redirect is pending
    redirect_ready = 1'b0;
    send(32'h500, 13'h010, 3'b000, 32'd3, 32'd3);
    step(1);
    chk("rr_rvalid_pre", 32'(redirect_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_rvalid", 32'(redirect_valid), 32'd0);
    chk("rr_rpc", redirect_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    step(1);
    chk("rr_ready", 32'(br_ready), 32'd1);
    chk("rr_count", 32'(taken_count), 32'd0);
    chk("rr_flush", 32'(flush), 32'd0);

    // Saturation of the taken counter
    force dut.taken_count_q = 16'hFFFE;
    #1 release dut.taken_count_q;
    chk("sat_preload", 32'(taken_count), 32'h0000_FFFE);
    @(negedge clk);
    send(32'h600, 13'h008, 3'b101, 32'd7, 32'd7);
    step(4);
    chk("sat_reach", 32'(taken_count), 32'h0000_FFFF);
    send(32'h600, 13'h008, 3'b111, 32'd7, 32'd7);
    step(1);
    chk("sat_rvalid", 32'(redirect_valid), 32'd1);
    step(3);
    chk("sat_hold", 32'(taken_count), 32'h0000_FFFF);
    chk("sat_ready", 32'(br_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
